// File: rtl/qspi_pkg.sv
// Shared quad-SPI definitions: bus and word widths, receive FSM states,
// nibble order, and the byte-length to nibble-count decode.
package qspi_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned NIB_W   = 4;
    localparam int unsigned NIB_N   = DATA_W / NIB_W;
    localparam int unsigned CNT_W   = $clog2(NIB_N);
    localparam int unsigned NCNT_W  = CNT_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } rx_state_e;

    typedef enum logic {
        ORD_MSB = 1'b0,
        ORD_LSB = 1'b1
    } qspi_order_e;

    // len 1..3 selects that many bytes, 0 selects the full four-byte word
    function automatic logic [NCNT_W-1:0] nib_count(input logic [1:0] len);
        logic [NCNT_W-1:0] n;
        if (len == 2'd0) begin
            n = NCNT_W'(NIB_N);
        end else begin
            n = NCNT_W'({len, 1'b0});
        end
        return n;
    endfunction

    // msb wins over lsb; neither set falls back to MSB-first
    function automatic qspi_order_e sel_order(input logic msb, input logic lsb);
        qspi_order_e o;
        if (msb) begin
            o = ORD_MSB;
        end else if (lsb) begin
            o = ORD_LSB;
        end else begin
            o = ORD_MSB;
        end
        return o;
    endfunction

endpackage

// File: rtl/qspi_rx_shift.sv
// Quad-SPI receive shifter: captures 2..8 nibbles from qsd_i into a word and
// offers it downstream with a valid/ready handshake.
module qspi_rx_shift
    import qspi_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              msb,
    input  logic              lsb,
    input  logic              start_i,
    input  logic [1:0]        len_i,
    input  logic              abort_i,
    input  logic [NIB_W-1:0]  qsd_i,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              busy_o,
    output logic              overrun_o
);

    rx_state_e          state_q;
    qspi_order_e        order_q;
    logic [DATA_W-1:0]  shreg_q;
    logic [DATA_W-1:0]  shreg_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   last_q;
    logic               accept_c;

    // A start is taken from IDLE, or from HOLD when the held word is consumed
    // in the same cycle so back-to-back captures have no bubble.
    always_comb begin
        accept_c = 1'b0;
        if (start_i) begin
            accept_c = (state_q == IDLE) || ((state_q == HOLD) && ready_i);
        end
    end

    // Shift register contents after capturing the current qsd_i nibble.
    always_comb begin
        shreg_d = shreg_q;
        if (order_q == ORD_LSB) begin
            shreg_d[{cnt_q, 2'b00} +: NIB_W] = qsd_i;
        end else begin
            shreg_d = {shreg_q[DATA_W-NIB_W-1:0], qsd_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            order_q   <= ORD_MSB;
            shreg_q   <= '0;
            cnt_q     <= '0;
            last_q    <= '0;
            data_o    <= '0;
            valid_o   <= 1'b0;
            busy_o    <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            if (accept_c) begin
                order_q <= sel_order(msb, lsb);
                last_q  <= CNT_W'(nib_count(len_i) - NCNT_W'(1));
                shreg_q <= '0;
                cnt_q   <= '0;
                valid_o <= 1'b0;
                busy_o  <= 1'b1;
                state_q <= SHIFT;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        valid_o <= 1'b0;
                        busy_o  <= 1'b0;
                    end
                    SHIFT: begin
                        if (abort_i) begin
                            shreg_q <= '0;
                            cnt_q   <= '0;
                            busy_o  <= 1'b0;
                            state_q <= IDLE;
                        end else if (cnt_q == last_q) begin
                            shreg_q <= shreg_d;
                            cnt_q   <= '0;
                            data_o  <= shreg_d;
                            valid_o <= 1'b1;
                            busy_o  <= 1'b0;
                            state_q <= HOLD;
                        end else begin
                            shreg_q <= shreg_d;
                            cnt_q   <= cnt_q + CNT_W'(1);
                        end
                    end
                    HOLD: begin
                        if (ready_i) begin
                            valid_o <= 1'b0;
                            state_q <= IDLE;
                        end else if (start_i) begin
                            overrun_o <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qspi_rx_shift.sv
// Scoreboarded bench for qspi_rx_shift: expected words are queued at capture
// start and popped when valid_o rises.
module tb_qspi_rx_shift;
    import qspi_pkg::*;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              msb, lsb, start_i, abort_i, ready_i;
    logic [1:0]        len_i;
    logic [NIB_W-1:0]  qsd_i;
    logic [DATA_W-1:0] data_o;
    logic              valid_o, busy_o, overrun_o;

    int                n_vec = 0;
    int                n_err = 0;
    logic [31:0]       exp_q[$];
    logic [31:0]       last_word = '0;
    logic              vprev = 1'b0;

    qspi_rx_shift dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .msb       (msb),
        .lsb       (lsb),
        .start_i   (start_i),
        .len_i     (len_i),
        .abort_i   (abort_i),
        .qsd_i     (qsd_i),
        .ready_i   (ready_i),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .busy_o    (busy_o),
        .overrun_o (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Nibble stream a transmitter would emit for word w in the given order,
    // packed first-nibble-at-top.
    function automatic logic [31:0] tx_stream(input logic [31:0] w, input qspi_order_e o);
        logic [31:0] s;
        s = w;
        if (o == ORD_LSB) begin
            for (int k = 0; k < 8; k++) s[31-4*k -: 4] = w[4*k +: 4];
        end
        return s;
    endfunction

    // Full capture: start edge, then one nibble per edge from the top of stream.
    task automatic capture(input logic [31:0] stream, input logic [1:0] len,
                           input logic m, input logic l, input logic [31:0] exp);
        int          n;
        logic [31:0] s;
        n = (len == 2'd0) ? 8 : 2 * int'(len);
        s = stream;
        msb = m; lsb = l; len_i = len; start_i = 1'b1;
        exp_q.push_back(exp);
        tick();
        start_i = 1'b0;
        chk("busy_at_start", 32'(busy_o), 32'd1);
        chk("valid_at_start", 32'(valid_o), 32'd0);
        chk("no_overrun_on_start", 32'(overrun_o), 32'd0);
        for (int k = 0; k < n; k++) begin
            qsd_i = s[31:28];
            s = s << 4;
            msb = 1'($urandom);
            lsb = 1'($urandom);
            len_i = 2'($urandom);
            tick();
            if (k < n - 1) begin
                chk("busy_shift", 32'(busy_o), 32'd1);
                chk("valid_shift", 32'(valid_o), 32'd0);
                chk("data_stable_shift", data_o, last_word);
            end else begin
                chk("valid_done", 32'(valid_o), 32'd1);
                chk("busy_done", 32'(busy_o), 32'd0);
            end
        end
        qsd_i = 4'($urandom);
        last_word = exp;
    endtask

    // Scoreboard: compare each newly presented word with the oldest expectation.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            vprev = 1'b0;
        end else begin
            if (valid_o && !vprev) begin
                if (exp_q.size() == 0) chk("sb_empty", 32'd0, 32'd1);
                else chk("sb_data", data_o, exp_q.pop_front());
            end
            vprev = valid_o;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0; msb = 1'b1; lsb = 1'b0; start_i = 1'b0; len_i = 2'd0;
        abort_i = 1'b0; qsd_i = 4'h0; ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_data", data_o, 32'h0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_overrun", 32'(overrun_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        // MSB-first and LSB-first full words
        capture(32'hABCD1234, 2'd0, 1'b1, 1'b0, 32'hABCD1234);
        tick();
        chk("accept_to_idle", 32'(valid_o), 32'd0);
        capture(32'hABCD1234, 2'd0, 1'b0, 1'b1, 32'h4321DCBA);
        tick();

        // Short lengths, msb=lsb=0 defaults to MSB-first
        capture(32'h5A000000, 2'd1, 1'b1, 1'b0, 32'h0000005A);
        tick();
        capture(32'h12345600, 2'd3, 1'b1, 1'b0, 32'h00123456);
        tick();
        capture(32'h98760000, 2'd2, 1'b0, 1'b0, 32'h00009876);
        tick();

        // Backpressure with a dropped start, then seamless accept+start
        ready_i = 1'b0;
        capture(32'h13579BDF, 2'd0, 1'b1, 1'b1, 32'h13579BDF);
        for (int c = 0; c < 5; c++) begin
            start_i = (c == 2);
            tick();
            start_i = 1'b0;
            chk("bp_overrun", 32'(overrun_o), (c == 2) ? 32'd1 : 32'd0);
            chk("bp_valid", 32'(valid_o), 32'd1);
            chk("bp_data", data_o, 32'h13579BDF);
        end
        ready_i = 1'b1;
        capture(32'h2468ACE0, 2'd0, 1'b0, 1'b1, 32'h0ECA8642);
        tick();

        // Abort on the third nibble
        msb = 1'b1; lsb = 1'b0; len_i = 2'd0; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        qsd_i = 4'hC; tick();
        qsd_i = 4'hA; tick();
        qsd_i = 4'hF; abort_i = 1'b1; tick();
        abort_i = 1'b0;
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_valid", 32'(valid_o), 32'd0);
        chk("abort_data", data_o, last_word);
        repeat (3) tick();
        chk("abort_no_valid", 32'(valid_o), 32'd0);
        capture(32'hCAFEF00D, 2'd0, 1'b1, 1'b0, 32'hCAFEF00D);
        tick();

        // Asynchronous reset in the middle of a capture
        msb = 1'b1; lsb = 1'b0; len_i = 2'd0; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            qsd_i = 4'(k + 9);
            tick();
        end
        #2 rst_ni = 1'b0;
        #1;
        chk("midrst_data", data_o, 32'h0);
        chk("midrst_valid", 32'(valid_o), 32'd0);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_overrun", 32'(overrun_o), 32'd0);
        last_word = '0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        capture(32'h12345678, 2'd0, 1'b1, 1'b0, 32'h12345678);
        tick();

        // Loopback of a transmitter stream in both orders
        capture(tx_stream(32'hDEADBEEF, ORD_MSB), 2'd0, 1'b1, 1'b0, 32'hDEADBEEF);
        tick();
        capture(tx_stream(32'hDEADBEEF, ORD_LSB), 2'd0, 1'b0, 1'b1, 32'hDEADBEEF);
        repeat (2) tick();

        chk("sb_left", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
